// File: rtl/rf_pkg.sv
// Shared constants and types for the register-bank write-back controller.
package rf_pkg;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-requester round-robin grant for the register-bank write port.
// rr=0 favours mem, rr=1 favours alu; the pointer moves to the loser on contention.
module wb_rr_arbiter
  import rf_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic mem_valid,
  input  logic alu_valid,
  output logic mem_gnt,
  output logic alu_gnt
);

  logic rr_q, rr_d;

  always_comb begin
    mem_gnt = mem_valid & (~alu_valid | ~rr_q);
    alu_gnt = alu_valid & (~mem_valid |  rr_q);
    rr_d    = rr_q;
    if (mem_valid && alu_valid) rr_d = ~rr_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates the bank write port and keeps the busy scoreboard.
// Optional RF_WB_FWD_EN adds forwarding of the in-flight bank write to decode.
module regfile_wb_ctrl
  import rf_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   rs_a,
  input  logic [AW-1:0]   rs_b,
  output logic            stall,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_addr,
  input  logic [DW-1:0]   alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_addr,
  input  logic [DW-1:0]   mem_data,
  output logic            mem_ready,
  output logic            enc,
  output logic [AW-1:0]   addrc,
  output logic [DW-1:0]   datac,
  output logic [NREGS-1:0] busy,
  output logic [AW:0]     outstanding,
  output logic            sb_err
`ifdef RF_WB_FWD_EN
  ,
  output logic            fwd_a_hit,
  output logic            fwd_b_hit,
  output logic [DW-1:0]   fwd_data
`endif
);

  localparam logic [AW:0]      CNT_ONE = 1;
  localparam logic [NREGS-1:0] BIT_ONE = 1;

  wb_req_t alu_req, mem_req, win_req;
  logic    alu_gnt, mem_gnt, wb_acc;
  logic    haz_a, haz_b, issue_acc, set_hit, clr_hit;
  logic [NREGS-1:0] set_vec, clr_vec;

  logic             enc_q, enc_d;
  logic [AW-1:0]    addrc_q, addrc_d;
  logic [DW-1:0]    datac_q, datac_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      outstanding_q, outstanding_d;
  logic             sb_err_q, sb_err_d;

  wb_rr_arbiter u_arb (
    .clock     (clock),
    .reset     (reset),
    .mem_valid (mem_valid),
    .alu_valid (alu_valid),
    .mem_gnt   (mem_gnt),
    .alu_gnt   (alu_gnt)
  );

  always_comb begin
    alu_req = '{valid: alu_valid, addr: alu_addr, data: alu_data};
    mem_req = '{valid: mem_valid, addr: mem_addr, data: mem_data};
    win_req = mem_gnt ? mem_req : alu_req;
    wb_acc  = (mem_gnt | alu_gnt) & win_req.valid;
  end

  // Hazard detection; with forwarding, a source being written this cycle is not a hazard.
  always_comb begin
    haz_a = busy_q[rs_a] & (rs_a != REG_ZERO);
    haz_b = busy_q[rs_b] & (rs_b != REG_ZERO);
`ifdef RF_WB_FWD_EN
    fwd_a_hit = enc_q & (addrc_q == rs_a) & (rs_a != REG_ZERO);
    fwd_b_hit = enc_q & (addrc_q == rs_b) & (rs_b != REG_ZERO);
    fwd_data  = datac_q;
    haz_a     = haz_a & ~fwd_a_hit;
    haz_b     = haz_b & ~fwd_b_hit;
`endif
    stall     = issue_valid & (haz_a | haz_b | busy_q[issue_rd]);
    issue_acc = issue_valid & ~stall;
  end

  always_comb begin
    enc_d   = wb_acc & (win_req.addr != REG_ZERO);
    addrc_d = addrc_q;
    datac_d = datac_q;
    if (enc_d) begin
      addrc_d = win_req.addr;
      datac_d = win_req.data;
    end

    set_vec = (issue_acc && issue_rd != REG_ZERO) ? (BIT_ONE << issue_rd) : '0;
    clr_vec = enc_q ? (BIT_ONE << addrc_q) : '0;
    busy_d  = (busy_q & ~clr_vec) | set_vec;

    // Only a genuine clear of a busy bit moves the count, so it cannot wrap.
    set_hit = |set_vec;
    clr_hit = enc_q & busy_q[addrc_q];
    outstanding_d = outstanding_q;
    if (set_hit && !clr_hit)      outstanding_d = outstanding_q + CNT_ONE;
    else if (!set_hit && clr_hit) outstanding_d = outstanding_q - CNT_ONE;

    sb_err_d = sb_err_q | (enc_q & ~busy_q[addrc_q]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enc_q         <= 1'b0;
      addrc_q       <= '0;
      datac_q       <= '0;
      busy_q        <= '0;
      outstanding_q <= '0;
      sb_err_q      <= 1'b0;
    end else begin
      enc_q         <= enc_d;
      addrc_q       <= addrc_d;
      datac_q       <= datac_d;
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
      sb_err_q      <= sb_err_d;
    end
  end

  assign alu_ready   = alu_gnt;
  assign mem_ready   = mem_gnt;
  assign enc         = enc_q;
  assign addrc       = addrc_q;
  assign datac       = datac_q;
  assign busy        = busy_q;
  assign outstanding = outstanding_q;
  assign sb_err      = sb_err_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed and randomized bench for regfile_wb_ctrl against a behavioural scoreboard model.
module tb_regfile_wb_ctrl;
  import rf_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic issue_valid;
  logic [AW-1:0] issue_rd, rs_a, rs_b;
  logic stall;
  logic alu_valid, mem_valid, alu_ready, mem_ready;
  logic [AW-1:0] alu_addr, mem_addr;
  logic [DW-1:0] alu_data, mem_data;
  logic enc;
  logic [AW-1:0] addrc;
  logic [DW-1:0] datac;
  logic [NREGS-1:0] busy;
  logic [AW:0] outstanding;
  logic sb_err;
`ifdef RF_WB_FWD_EN
  logic fwd_a_hit, fwd_b_hit;
  logic [DW-1:0] fwd_data;
`endif

  always #5 clock = ~clock;

  regfile_wb_ctrl dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs_a(rs_a), .rs_b(rs_b), .stall(stall),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .enc(enc), .addrc(addrc), .datac(datac), .busy(busy), .outstanding(outstanding),
    .sb_err(sb_err)
`ifdef RF_WB_FWD_EN
    , .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit), .fwd_data(fwd_data)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference state: which registers await a write, the pending bank write, fairness, error flag.
  logic [31:0] m_busy;
  bit          m_fav_alu;
  bit          m_enc;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = '0; m_fav_alu = 0; m_enc = 0; m_addr = '0; m_data = '0; m_err = 0;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_rd = 0; rs_a = 0; rs_b = 0;
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0;
  endtask

  function automatic bit exp_mem_rdy();
    return mem_valid && (!alu_valid || !m_fav_alu);
  endfunction

  function automatic bit exp_alu_rdy();
    return alu_valid && (!mem_valid || m_fav_alu);
  endfunction

  function automatic bit fwd_hit(input logic [4:0] rs);
`ifdef RF_WB_FWD_EN
    return m_enc && (m_addr == rs) && (rs != 0);
`else
    return 0;
`endif
  endfunction

  function automatic bit exp_stall();
    bit ha, hb;
    ha = m_busy[rs_a] && rs_a != 0 && !fwd_hit(rs_a);
    hb = m_busy[rs_b] && rs_b != 0 && !fwd_hit(rs_b);
    return issue_valid && (ha || hb || m_busy[issue_rd]);
  endfunction

  task automatic settle();
    #1;
    chk("alu_ready", alu_ready, exp_alu_rdy());
    chk("mem_ready", mem_ready, exp_mem_rdy());
    chk("stall", stall, exp_stall());
    chk("enc", enc, m_enc);
    chk("addrc", addrc, m_addr);
    chk("datac", datac, m_data);
    chk("busy", busy, m_busy);
    chk("outstanding", outstanding, $countones(m_busy));
    chk("sb_err", sb_err, m_err);
`ifdef RF_WB_FWD_EN
    chk("fwd_a_hit", fwd_a_hit, fwd_hit(rs_a));
    chk("fwd_b_hit", fwd_b_hit, fwd_hit(rs_b));
    chk("fwd_data", fwd_data, m_data);
`endif
  endtask

  task automatic tick();
    bit mg, ag, iss;
    logic [4:0] wa;
    mg  = exp_mem_rdy();
    ag  = exp_alu_rdy();
    iss = issue_valid && !exp_stall();
    if (m_enc) begin
      if (!m_busy[m_addr]) m_err = 1;
      m_busy[m_addr] = 0;
    end
    if (iss && issue_rd != 0) m_busy[issue_rd] = 1;
    if (mem_valid && alu_valid) m_fav_alu = !m_fav_alu;
    m_enc = 0;
    if (mg || ag) begin
      wa = mg ? mem_addr : alu_addr;
      if (wa != 0) begin
        m_enc = 1; m_addr = wa; m_data = mg ? mem_data : alu_data;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 0;
    idle_inputs();
    model_reset();
    @(posedge clock);
    #1;
    reset = 1;
  endtask

  function automatic logic [4:0] pick_addr();
    int s;
    s = $urandom_range(1, 31);
    if (m_busy != 0 && $urandom_range(0, 3) != 0)
      for (int i = 0; i < 32; i++)
        if (m_busy[(s + i) % 32]) return 5'((s + i) % 32);
    return 5'(s);
  endfunction

  initial begin
    int pulses;
    reset = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    settle();
    chk("reset_outstanding", outstanding, 0);
    reset = 1;
    tick();

    // Single mem write-back to r5
    issue_valid = 1; issue_rd = 5;
    settle(); tick();
    issue_valid = 0; mem_valid = 1; mem_addr = 5; mem_data = 32'hDEADBEEF;
    settle(); chk("mem5_ready", mem_ready, 1); tick();
    mem_valid = 0;
    settle();
    chk("mem5_enc", enc, 1); chk("mem5_addrc", addrc, 5); chk("mem5_datac", datac, 32'hDEADBEEF);
    tick();
    settle(); chk("mem5_busy_clear", busy[5], 0); tick();

    // Contention from reset: mem, alu, mem, alu
    do_reset();
    pulses = 0;
    alu_valid = 1; mem_valid = 1;
    for (int i = 0; i < 4; i++) begin
      alu_addr = 5'(10 + i); alu_data = 32'(i); mem_addr = 5'(20 + i); mem_data = 32'(100 + i);
      settle();
      chk("rr_mem_gnt", mem_ready, (i % 2) == 0);
      chk("rr_alu_gnt", alu_ready, (i % 2) == 1);
      tick();
      pulses += int'(enc);
    end
    alu_valid = 0; mem_valid = 0;
    chk("enc_pulses", pulses, 4);
    settle(); tick();

    // RAW stall on r7 until its write lands
    do_reset();
    issue_valid = 1; issue_rd = 7;
    settle(); tick();
    issue_rd = 8; rs_a = 7;
    settle(); chk("raw_stall0", stall, 1); tick();
    alu_valid = 1; alu_addr = 7; alu_data = 32'h77;
    settle(); chk("raw_stall1", stall, 1); chk("raw_out1", outstanding, 1); tick();
    alu_valid = 0;
    settle();
    chk("raw_enc", enc, 1);
`ifdef RF_WB_FWD_EN
    chk("raw_fwd_stall", stall, 0);
    tick();
    settle(); chk("raw_fwd_out", outstanding, 1); tick();
`else
    chk("raw_stall2", stall, 1);
    tick();
    settle(); chk("raw_stall3", stall, 0); chk("raw_out0", outstanding, 0); tick();
`endif
    issue_valid = 0; rs_a = 0;

    // WAW stall on r3 and an alu write to r0
    issue_valid = 1; issue_rd = 3;
    settle(); tick();
    alu_valid = 1; alu_addr = 0; alu_data = 32'h1234;
    settle(); chk("waw_stall", stall, 1); chk("r0_ready", alu_ready, 1); tick();
    alu_valid = 0; issue_valid = 0;
    settle(); chk("r0_enc", enc, 0); chk("r0_busy", busy, 32'h108); tick();

    // Write-back to non-busy r9 raises the sticky error
    mem_valid = 1; mem_addr = 9; mem_data = 32'h99;
    settle(); tick();
    mem_valid = 0;
    settle(); tick();
    settle(); chk("sb_err_set", sb_err, 1); tick();
    repeat (3) begin settle(); tick(); end
    chk("sb_err_sticky", sb_err, 1);

    // Asynchronous reset with a write pending
    mem_valid = 1; mem_addr = 3; mem_data = 32'hABCD;
    settle(); tick();
    mem_valid = 0;
    #1 reset = 0;
    #1;
    chk("ar_enc", enc, 0); chk("ar_addrc", addrc, 0); chk("ar_datac", datac, 0);
    chk("ar_busy", busy, 0); chk("ar_out", outstanding, 0); chk("ar_err", sb_err, 0);
    model_reset();
    #1 reset = 1;
    settle(); tick();

`ifdef RF_WB_FWD_EN
    // Forwarding removes the stall while r4 is being written
    issue_valid = 1; issue_rd = 4;
    settle(); tick();
    issue_valid = 0; mem_valid = 1; mem_addr = 4; mem_data = 32'h55;
    settle(); tick();
    mem_valid = 0; issue_valid = 1; issue_rd = 12; rs_b = 4;
    settle();
    chk("fwd_busy4", busy[4], 1); chk("fwd_hit_b", fwd_b_hit, 1);
    chk("fwd_val", fwd_data, 32'h55); chk("fwd_stall", stall, 0);
    tick();
    idle_inputs();
`endif

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rd    = 5'($urandom_range(0, 31));
      rs_a        = 5'($urandom_range(0, 31));
      rs_b        = 5'($urandom_range(0, 31));
      alu_valid   = ($urandom_range(0, 2) == 0);
      alu_addr    = pick_addr();
      alu_data    = $urandom;
      mem_valid   = ($urandom_range(0, 2) == 0);
      mem_addr    = pick_addr();
      mem_data    = $urandom;
      settle();
      tick();
    end
    idle_inputs();
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-back controller for the 32×32 register bank. It arbitrates the bank's single write port between the ALU and load/memory write-back paths with round-robin valid/ready handshakes. A per-register busy scoreboard stalls decode on RAW and WAW hazards. It drives the bank's `enc`/`addrc`/`datac` inputs from registered outputs and sits between the execute/memory stages and the register bank.

## Interface
- `NREGS`, 32: number of architectural registers.
- `AW`, 5: register address width.
- `DW`, 32: data width.

- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset.
- `issue_valid`  in  1: decode wants to issue an instruction writing `issue_rd`.
- `issue_rd`  in  AW: destination register of the issuing instruction.
- `rs_a`, `rs_b`  in  AW: source registers of the instruction in decode.
- `stall`  out  1: decode must hold; the issue is not accepted.
- `alu_valid`, `alu_addr` (AW), `alu_data` (DW)  in: ALU write-back request.
- `alu_ready`  out  1: ALU request accepted this cycle.
- `mem_valid`, `mem_addr` (AW), `mem_data` (DW)  in: load write-back request.
- `mem_ready`  out  1: load request accepted this cycle.
- `enc`  out  1; `addrc`  out  AW; `datac`  out  DW: register-bank write port.
- `busy`  out  NREGS: scoreboard vector.
- `outstanding`  out  AW+1: count of set busy bits.
- `sb_err`  out  1: sticky flag for a write-back to a non-busy register.

## Operation
- Arbitration is combinational from the valid inputs and the round-robin pointer `rr`. `rr=0` favours mem; `rr=1` favours alu.
  - One valid requester: that requester gets ready=1.
  - Both valid: the favoured requester gets ready; then `rr` toggles to the loser.
  - At most one ready per cycle. A handshake is valid & ready.
- Accepted write with addr≠0: the next cycle has `enc=1`, and `addrc`/`datac` carry the accepted values.
- Accepted write with addr=0: the handshake completes, but `enc` stays 0 and `busy` is untouched.
- No accept: `enc=0`. `addrc`/`datac` hold their previous values.
- Stall conditions: `stall = issue_valid & (hazA | hazB | busy[issue_rd])`.
  - `hazA = busy[rs_a] & rs_a≠0`; `hazB` is the same for `rs_b`.
  - r0 is never busy.
- Issue accept is `issue_valid & !stall`. On accept with `issue_rd≠0`, `busy[issue_rd]` sets at the next edge.
- Busy clear: `busy[addrc]` clears at the edge that ends a cycle with `enc=1`.
  - The bank writes at that same edge, so decode reads the new value from the following cycle.
- Set and clear on the same edge for the same register cannot occur, because WAW stalls the issue.
- Clearing a non-busy register sets `sb_err` until reset.
- `outstanding` is incremented on a set and decremented on a clear. Both on one edge means net zero. It never wraps (range 0..31).

## Timing
- Reset values: `enc=0`, `addrc=0`, `datac=0`, `busy=0`, `outstanding=0`, `sb_err=0`, `rr=0`.
- Reset is asynchronous. A reset asserted mid-handshake discards the pending write.
- Ready has 0-cycle latency. Handshake at cycle N gives `enc` high in cycle N+1 and busy clear at the end of N+1.
- `stall` is combinational from the `busy` register and the current inputs.
- Sustained throughput: one write per cycle.

## Configuration
- `RF_WB_FWD_EN` defined: adds outputs `fwd_a_hit`, `fwd_b_hit` (1 bit each) and `fwd_data` (DW).
  - `fwd_x_hit = enc & addrc==rs_x & rs_x≠0`; `fwd_data = datac`.
  - `hazA`/`hazB` ignore a busy bit whose register is being written this cycle (`fwd_x_hit`), saving one stall cycle.
- Undefined: no forwarding ports, and the stall rules are as above.

## Structure
- Shared package `rf_pkg`: `NREGS`/`AW`/`DW` constants, the `wb_req_t` struct `{valid, addr, data}`, and the `REG_ZERO` constant.
- One sub-module: `wb_rr_arbiter`, a 2-requester round-robin grant with the `rr` pointer. The scoreboard, output registers and counter live in the top.

## Test plan
- Reset, then mem writes r5=0xDEADBEEF → `mem_ready=1` that cycle; next cycle `enc=1`, `addrc=5`, `datac=0xDEADBEEF`.
- alu and mem both valid for 4 cycles from reset → grants mem, alu, mem, alu; 4 `enc` pulses.
- Issue rd=7, then decode with rs_a=7 → `stall=1` until the cycle after the r7 write's `enc` pulse; `outstanding` goes 1→0.
- Issue rd=3 while `busy[3]` is set → `stall=1`; alu write to r0 → `alu_ready=1`, `enc` stays 0, `busy` unchanged.
- Write-back to non-busy r9 → `sb_err=1` and it remains high; async reset mid-stream → all outputs at reset values immediately.
- With `RF_WB_FWD_EN`: while `enc=1`, `addrc=4`, `datac=0x55`, rs_b=4 and `busy[4]=1` → `fwd_b_hit=1`, `fwd_data=0x55`, `stall=0`.
